// File: rtl/music_track_scroller.sv
// music_track_scroller
//   Producer side of the 4-track note view. Note codes arrive from a song
//   source over a valid/ready handshake and wait in a small FIFO. On every
//   beat the view scrolls track3->track2->track1->track0, track3 takes the
//   FIFO head, and the note leaving track0 is issued on play_note for the
//   buzzer. Note code 0 is a rest/empty slot everywhere.
//
// Parameters
//   BEAT_CYCLES  clock cycles per beat (>= 2)
//   FIFO_DEPTH   note FIFO entries, power of two, 2..16
//
// Ports
//   EGO1_Clock   in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   note_in      in   6-bit note code from the song source
//   note_valid   in   note_in valid
//   note_ready   out  FIFO can accept (transfer on note_valid & note_ready)
//   song_end     in   single-cycle pulse: no further notes follow
//   run          in   level: 1 = play, 0 = pause
//   track0..3    out  scrolling view, track0 = next note to play
//   play_note    out  note that left track0 on the last beat
//   play_strobe  out  pulse with a beat whose outgoing track0 was non-zero
//   beat_tick    out  pulse on every scroll
//   underrun     out  pulse when a PLAYING beat found the FIFO empty
//   done         out  pulse on DRAIN->IDLE
//   busy         out  state != IDLE
//   fifo_count   out  entries held, 0..FIFO_DEPTH
module music_track_scroller #(
   parameter int BEAT_CYCLES = 25_000_000,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic       EGO1_Clock,
   input  logic       reset,
   input  logic [5:0] note_in,
   input  logic       note_valid,
   output logic       note_ready,
   input  logic       song_end,
   input  logic       run,
   output logic [5:0] track0,
   output logic [5:0] track1,
   output logic [5:0] track2,
   output logic [5:0] track3,
   output logic [5:0] play_note,
   output logic       play_strobe,
   output logic       beat_tick,
   output logic       underrun,
   output logic       done,
   output logic       busy,
   output logic [4:0] fifo_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(BEAT_CYCLES);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_PLAYING = 2'd1;
   localparam logic [1:0] S_PAUSED  = 2'd2;
   localparam logic [1:0] S_DRAIN   = 2'd3;

   logic [1:0]    state;
   logic [1:0]    state_next;
   logic          end_flag;
   logic [CW-1:0] beat_cnt;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [4:0]    count;
   logic [4:0]    count_next;
   logic [5:0]    mem [FIFO_DEPTH];

   logic          scrolling;
   logic          beat;
   logic          push;
   logic          pop;
   logic          drained;
   logic          finish;
   logic [5:0]    t0_next;
   logic [5:0]    t1_next;
   logic [5:0]    t2_next;
   logic [5:0]    t3_next;

   assign scrolling  = (state == S_PLAYING) || (state == S_DRAIN);
   assign beat       = scrolling && (beat_cnt == CW'(BEAT_CYCLES - 1));
   assign note_ready = (count < 5'(FIFO_DEPTH));
   assign push       = note_valid && note_ready;
   // Pop decision uses the count before this cycle's push, so a note pushed
   // into an empty FIFO on a beat is stored rather than scrolled in.
   assign pop        = beat && (count != 5'd0);
   assign busy       = (state != S_IDLE);
   assign fifo_count = count;
   assign finish     = (state == S_DRAIN) && (state_next == S_IDLE);

   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + 5'd1;
         2'b01:   count_next = count - 5'd1;
         default: count_next = count;
      endcase
   end

   always_comb begin
      t0_next = track0;
      t1_next = track1;
      t2_next = track2;
      t3_next = track3;
      if (beat) begin
         t0_next = track1;
         t1_next = track2;
         t2_next = track3;
         t3_next = pop ? mem[rd_ptr] : 6'd0;
      end
   end

   // Drain completion looks at the view and FIFO as they will be after this
   // cycle's scroll, so done lines up with the beat that empties the view.
   assign drained = (count_next == 5'd0) && (t0_next == 6'd0) && (t1_next == 6'd0)
                    && (t2_next == 6'd0) && (t3_next == 6'd0);

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:    if (run && (count != 5'd0)) state_next = S_PLAYING;
         S_PLAYING: begin
            if (end_flag)  state_next = S_DRAIN;
            else if (!run) state_next = S_PAUSED;
         end
         S_PAUSED:  if (run) state_next = end_flag ? S_DRAIN : S_PLAYING;
         S_DRAIN:   if (drained) state_next = S_IDLE;
         default:   state_next = S_IDLE;
      endcase
   end

   // FIFO storage carries no reset; the pointers and count define its contents.
   always_ff @(posedge EGO1_Clock) begin
      if (push) mem[wr_ptr] <= note_in;
   end

   always_ff @(posedge EGO1_Clock or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         end_flag    <= 1'b0;
         beat_cnt    <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= 5'd0;
         track0      <= 6'd0;
         track1      <= 6'd0;
         track2      <= 6'd0;
         track3      <= 6'd0;
         play_note   <= 6'd0;
         play_strobe <= 1'b0;
         beat_tick   <= 1'b0;
         underrun    <= 1'b0;
         done        <= 1'b0;
      end else begin
         state <= state_next;

         // The beat counter only advances while scrolling; PAUSED holds it.
         if ((state == S_IDLE) && (state_next == S_PLAYING)) beat_cnt <= '0;
         else if (scrolling) beat_cnt <= beat ? '0 : beat_cnt + CW'(1);

         if (finish) end_flag <= 1'b0;
         else if (song_end && (state != S_IDLE)) end_flag <= 1'b1;

         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count_next;

         track0 <= t0_next;
         track1 <= t1_next;
         track2 <= t2_next;
         track3 <= t3_next;

         if (beat) play_note <= track0;
         beat_tick   <= beat;
         play_strobe <= beat && (track0 != 6'd0);
         underrun    <= beat && (state == S_PLAYING) && (count == 5'd0);
         done        <= finish;
      end
   end

endmodule

// File: tb/tb_music_track_scroller.sv
// tb_music_track_scroller
//   Drives music_track_scroller (BEAT_CYCLES=4, FIFO_DEPTH=4) with directed
//   scenarios and checks every output each cycle against a queue-based model
//   of the note view, plus hand-computed expectations at key beats.
module tb_music_track_scroller;

   localparam int BEAT  = 4;
   localparam int DEPTH = 4;

   logic       clk;
   logic       rst_n;
   logic [5:0] note_in;
   logic       note_valid;
   logic       note_ready;
   logic       song_end;
   logic       run;
   logic [5:0] track0, track1, track2, track3;
   logic [5:0] play_note;
   logic       play_strobe, beat_tick, underrun, done, busy;
   logic [4:0] fifo_count;

   int total = 0;
   int bad   = 0;
   bit armed = 0;

   music_track_scroller #(.BEAT_CYCLES(BEAT), .FIFO_DEPTH(DEPTH)) dut (
      .EGO1_Clock (clk),
      .reset      (rst_n),
      .note_in    (note_in),
      .note_valid (note_valid),
      .note_ready (note_ready),
      .song_end   (song_end),
      .run        (run),
      .track0     (track0),
      .track1     (track1),
      .track2     (track2),
      .track3     (track3),
      .play_note  (play_note),
      .play_strobe(play_strobe),
      .beat_tick  (beat_tick),
      .underrun   (underrun),
      .done       (done),
      .busy       (busy),
      .fifo_count (fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input bit run_v, input bit end_v, input int cycles);
      run      = run_v;
      song_end = end_v;
      repeat (cycles) tick();
   endtask

   // Ticks until beat_tick is seen; n is the number of ticks it took.
   task automatic waitBeat(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!beat_tick && n < 40);
      if (!beat_tick) begin
         total++;
         bad++;
         $display("[TB] FAIL beat_timeout: no beat_tick within 40 cycles at %0t", $time);
      end
   endtask

   // Song source: holds each note until it is accepted.
   logic [5:0] src_q[$];
   bit         acc;
   initial begin
      note_valid = 1'b0;
      note_in    = 6'd0;
      forever begin
         @(negedge clk);
         acc = note_valid && note_ready;
         @(posedge clk);
         #1;
         if (acc && src_q.size() > 0) void'(src_q.pop_front());
         note_valid = (src_q.size() > 0);
         note_in    = (src_q.size() > 0) ? src_q[0] : 6'd0;
      end
   end

   // Behavioural model: a note queue, a 4-slot view and a beat phase.
   typedef enum {M_IDLE, M_PLAY, M_PAUSE, M_DRAIN} mode_t;
   mode_t      m_mode;
   logic [5:0] m_q[$];
   int         m_tr[4];
   int         m_phase;
   bit         m_end;
   int         m_play;
   bit         m_tick, m_strobe, m_under, m_done;
   int         n0;
   bit         beat_now, push_now;
   mode_t      prev;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode = M_IDLE;
         m_q.delete();
         for (int i = 0; i < 4; i++) m_tr[i] = 0;
         m_phase = 0;
         m_end   = 0;
         m_play  = 0;
         m_tick  = 0;
         m_strobe = 0;
         m_under = 0;
         m_done  = 0;
      end else begin
         prev     = m_mode;
         n0       = m_q.size();
         push_now = note_valid && (n0 < DEPTH);
         beat_now = (prev == M_PLAY || prev == M_DRAIN) && (m_phase == BEAT - 1);
         m_tick   = beat_now;
         m_strobe = 0;
         m_under  = 0;
         m_done   = 0;
         if (beat_now) begin
            m_strobe = (m_tr[0] != 0);
            m_play   = m_tr[0];
            for (int i = 0; i < 3; i++) m_tr[i] = m_tr[i + 1];
            if (n0 > 0) m_tr[3] = int'(m_q.pop_front());
            else begin
               m_tr[3] = 0;
               m_under = (prev == M_PLAY);
            end
         end
         if (push_now) m_q.push_back(note_in);
         if (prev == M_PLAY || prev == M_DRAIN) m_phase = beat_now ? 0 : m_phase + 1;
         case (prev)
            M_IDLE:  if (run && n0 != 0) begin m_mode = M_PLAY; m_phase = 0; end
            M_PLAY:  if (m_end) m_mode = M_DRAIN; else if (!run) m_mode = M_PAUSE;
            M_PAUSE: if (run) m_mode = m_end ? M_DRAIN : M_PLAY;
            M_DRAIN: if (m_q.size() == 0 && m_tr[0] == 0 && m_tr[1] == 0 &&
                         m_tr[2] == 0 && m_tr[3] == 0) begin
                        m_mode = M_IDLE;
                        m_done = 1;
                     end
            default: m_mode = M_IDLE;
         endcase
         if (m_done) m_end = 0;
         else if (song_end && prev != M_IDLE) m_end = 1;
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         checkOutput("track0", int'(track0), m_tr[0]);
         checkOutput("track1", int'(track1), m_tr[1]);
         checkOutput("track2", int'(track2), m_tr[2]);
         checkOutput("track3", int'(track3), m_tr[3]);
         checkOutput("play_note", int'(play_note), m_play);
         checkOutput("play_strobe", int'(play_strobe), int'(m_strobe));
         checkOutput("beat_tick", int'(beat_tick), int'(m_tick));
         checkOutput("underrun", int'(underrun), int'(m_under));
         checkOutput("done", int'(done), int'(m_done));
         checkOutput("busy", int'(busy), int'(m_mode != M_IDLE));
         checkOutput("fifo_count", int'(fifo_count), m_q.size());
         checkOutput("note_ready", int'(note_ready), int'(m_q.size() < DEPTH));
      end
   end

   int n;
   int strobes[$];
   bit seen_done;

   initial begin
      rst_n    = 1'b1;
      run      = 1'b0;
      song_end = 1'b0;
      #2 rst_n = 1'b0;
      armed = 1;
      applyStimulus(0, 0, 2);
      rst_n = 1'b1;

      $display("[TB] reset values");
      checkOutput("rst_track0", int'(track0), 0);
      checkOutput("rst_track3", int'(track3), 0);
      checkOutput("rst_note_ready", int'(note_ready), 1);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_fifo_count", int'(fifo_count), 0);

      $display("[TB] fill FIFO while stopped");
      for (int i = 1; i <= 5; i++) src_q.push_back(6'(i));
      applyStimulus(0, 0, 8);
      checkOutput("full_count", int'(fifo_count), 4);
      checkOutput("full_ready", int'(note_ready), 0);
      checkOutput("full_busy", int'(busy), 0);

      $display("[TB] play");
      applyStimulus(1, 0, 1);
      checkOutput("play_busy", int'(busy), 1);
      waitBeat(n);
      checkOutput("beat1_spacing", n, 4);
      checkOutput("beat1_track3", int'(track3), 1);
      checkOutput("beat1_count", int'(fifo_count), 3);
      waitBeat(n);
      checkOutput("beat2_spacing", n, 4);
      checkOutput("beat2_track2", int'(track2), 1);
      checkOutput("beat2_track3", int'(track3), 2);
      checkOutput("beat2_count", int'(fifo_count), 3);

      $display("[TB] pause mid-beat");
      applyStimulus(1, 0, 2);
      applyStimulus(0, 0, 10);
      checkOutput("pause_track2", int'(track2), 1);
      checkOutput("pause_track3", int'(track3), 2);
      run = 1'b1;
      waitBeat(n);
      checkOutput("resume_spacing", n, 2);
      checkOutput("beat3_track1", int'(track1), 1);
      checkOutput("beat3_track3", int'(track3), 3);
      checkOutput("beat3_count", int'(fifo_count), 2);
      waitBeat(n);
      checkOutput("beat4_track0", int'(track0), 1);
      checkOutput("beat4_track3", int'(track3), 4);
      waitBeat(n);
      checkOutput("beat5_play_note", int'(play_note), 1);
      checkOutput("beat5_strobe", int'(play_strobe), 1);
      checkOutput("beat5_track3", int'(track3), 5);

      $display("[TB] underrun");
      waitBeat(n);
      checkOutput("beat6_underrun", int'(underrun), 1);
      checkOutput("beat6_track3", int'(track3), 0);
      checkOutput("beat6_play_note", int'(play_note), 2);
      waitBeat(n);
      checkOutput("beat7_underrun", int'(underrun), 1);
      checkOutput("beat7_busy", int'(busy), 1);

      $display("[TB] reset while playing, then drain");
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_count", int'(fifo_count), 0);
      checkOutput("midrst_track0", int'(track0), 0);
      applyStimulus(0, 0, 1);
      rst_n = 1'b1;
      src_q.push_back(6'd7);
      src_q.push_back(6'd9);
      applyStimulus(0, 0, 4);
      applyStimulus(1, 0, 1);
      applyStimulus(1, 1, 1);
      song_end = 1'b0;
      seen_done = 0;
      for (int i = 0; i < 60 && !seen_done; i++) begin
         tick();
         if (play_strobe) strobes.push_back(int'(play_note));
         if (done) seen_done = 1;
      end
      checkOutput("drain_done_seen", int'(seen_done), 1);
      checkOutput("drain_strobes", strobes.size(), 2);
      if (strobes.size() == 2) begin
         checkOutput("drain_first", strobes[0], 7);
         checkOutput("drain_second", strobes[1], 9);
      end
      checkOutput("drain_tracks", int'(track0 | track1 | track2 | track3), 0);
      tick();
      checkOutput("drain_busy", int'(busy), 0);

      $display("[TB] song_end in IDLE is ignored");
      applyStimulus(0, 1, 1);
      song_end = 1'b0;
      src_q.push_back(6'd12);
      applyStimulus(0, 0, 3);
      applyStimulus(1, 0, 24);
      checkOutput("idle_end_busy", int'(busy), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "[TB] watchdog");
   end

endmodule
